if_fetch_unit: RTL and testbench

Instruction-fetch front end that sits directly upstream of the instruction ROM and feeds the IF/ID boundary. It owns the program counter and drives the ROM chip-enable and address. It captures the combinational ROM read into a 2-entry fetch buffer and hands {pc, inst} to decode over a valid/ready handshake. Branch and flush redirects from ID/ctrl are handled here.

---
 rtl/if_fetch_unit.sv | 116 +++++++++++
 tb/tb_if_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the instruction ROM and buffers
// {pc, inst} pairs in a 2-entry FIFO feeding decode over a valid/ready handshake.
module if_fetch_unit #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned INST_W = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] new_pc,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_target_address_i,
   output logic              rom_ce,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [INST_W-1:0] rom_inst,
   output logic              id_valid,
   output logic [ADDR_W-1:0] id_pc,
   output logic [INST_W-1:0] id_inst,
   input  logic              id_ready
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              rom_ce_q;
   logic [ADDR_W-1:0] ent_pc_q   [2];
   logic [INST_W-1:0] ent_inst_q [2];
   logic              head_q, head_d;
   logic              tail_q, tail_d;
   logic [1:0]        count_q, count_d;

   logic pop;
   logic fire;
   logic redirect;

   // Target low bits are dropped; misaligned redirects are silently truncated.
   logic unused_low_bits;
   assign unused_low_bits = ^{new_pc[1:0], branch_target_address_i[1:0]};

   assign pop      = id_valid & id_ready;
   assign redirect = flush | branch_flag_i;
   assign fire     = rom_ce_q & ~stall & ~redirect & ((count_q < 2'd2) | pop);

   always_comb begin
      pc_d    = pc_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         pc_d    = {new_pc[ADDR_W-1:2], 2'b00};
         head_d  = 1'b0;
         tail_d  = 1'b0;
         count_d = 2'd0;
      end else if (branch_flag_i) begin
         pc_d    = {branch_target_address_i[ADDR_W-1:2], 2'b00};
         head_d  = 1'b0;
         tail_d  = 1'b0;
         count_d = 2'd0;
      end else begin
         if (fire) begin
            pc_d   = pc_q + ADDR_W'(4);
            tail_d = tail_q + 1'b1;
         end
         if (pop) begin
            head_d = head_q + 1'b1;
         end
         unique case ({fire, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q     <= RESET_PC;
         rom_ce_q <= 1'b0;
         head_q   <= 1'b0;
         tail_q   <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         pc_q     <= pc_d;
         rom_ce_q <= 1'b1;
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ent_pc_q[0]   <= '0;
         ent_pc_q[1]   <= '0;
         ent_inst_q[0] <= '0;
         ent_inst_q[1] <= '0;
      end else if (fire) begin
         ent_pc_q[tail_q]   <= pc_q;
         ent_inst_q[tail_q] <= rom_inst;
      end
   end

   // Outputs depend only on registered state, never on rom_inst directly.
   always_comb begin
      rom_ce   = rom_ce_q;
      rom_addr = pc_q;
      id_valid = (count_q != 2'd0);
      id_pc    = '0;
      id_inst  = '0;
      if (count_q != 2'd0) begin
         id_pc   = ent_pc_q[head_q];
         id_inst = ent_inst_q[head_q];
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: queue-based reference model checked every cycle, plus
// directed literal checks for reset, back-pressure, redirects and PC wrap.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        branch_flag_i;
   logic [31:0] bta;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic [31:0] rom_inst;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_ready;

   int checks = 0;
   int errors = 0;

   if_fetch_unit #(
      .ADDR_W   (32),
      .INST_W   (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .stall                   (stall),
      .flush                   (flush),
      .new_pc                  (new_pc),
      .branch_flag_i           (branch_flag_i),
      .branch_target_address_i (bta),
      .rom_ce                  (rom_ce),
      .rom_addr                (rom_addr),
      .rom_inst                (rom_inst),
      .id_valid                (id_valid),
      .id_pc                   (id_pc),
      .id_inst                 (id_inst),
      .id_ready                (id_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return 32'h1000_0000 + {2'b00, a[31:2]};
   endfunction

   assign rom_inst = rom_word(rom_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   // Reference model: PC, chip enable and a queue of fetched {pc, inst} pairs.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc = 32'h0;
   logic        m_ce = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         if (!rst) begin
            m_pc = 32'h0;
            m_ce = 1'b0;
            mq.delete();
         end else begin
            logic m_pop;
            logic m_fire;
            m_pop  = (mq.size() != 0) && id_ready;
            m_fire = 1'b0;
            if (flush) begin
               m_pc = new_pc & ~32'h3;
               mq.delete();
            end else if (branch_flag_i) begin
               m_pc = bta & ~32'h3;
               mq.delete();
            end else begin
               m_fire = m_ce && !stall && ((mq.size() < 2) || m_pop);
               if (m_pop) void'(mq.pop_front());
               if (m_fire) begin
                  mq.push_back({m_pc, rom_word(m_pc)});
                  m_pc = m_pc + 32'd4;
               end
            end
            m_ce = 1'b1;
         end
         @(negedge clk);
         chk("model_rom_ce", {31'b0, rom_ce}, {31'b0, m_ce});
         chk("model_rom_addr", rom_addr, m_pc);
         chk("model_id_valid", {31'b0, id_valid}, {31'b0, (mq.size() != 0)});
         chk("model_id_pc", id_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
         chk("model_id_inst", id_inst, (mq.size() != 0) ? mq[0].inst : 32'h0);
      end
   end

   initial begin
      rst = 1'b0; stall = 1'b0; flush = 1'b0; new_pc = '0;
      branch_flag_i = 1'b0; bta = '0; id_ready = 1'b1;
      step;
      chk("reset_id_valid", {31'b0, id_valid}, 32'd0);
      chk("reset_rom_addr", rom_addr, 32'h0);
      step;
      rst = 1'b1;
      chk("release_ce_low", {31'b0, rom_ce}, 32'd0);
      step;
      chk("ce_high", {31'b0, rom_ce}, 32'd1);
      chk("no_valid_yet", {31'b0, id_valid}, 32'd0);
      step;
      chk("first_valid", {31'b0, id_valid}, 32'd1);
      chk("first_pc", id_pc, 32'h0);
      chk("first_inst", id_inst, 32'h1000_0000);
      step;
      chk("seq_pc4", id_pc, 32'h4);
      step;
      chk("seq_pc8", id_pc, 32'h8);

      // Back-pressure: restart at 0 and hold id_ready low for five cycles.
      branch_flag_i = 1'b1; bta = 32'h0; id_ready = 1'b0;
      step;
      branch_flag_i = 1'b0;
      repeat (4) step;
      chk("full_head_pc", id_pc, 32'h0);
      chk("full_rom_addr", rom_addr, 32'h8);
      id_ready = 1'b1;
      step;
      chk("drain_pc4", id_pc, 32'h4);
      step;
      chk("drain_pc8", id_pc, 32'h8);

      // Branch with simultaneous pop while the buffer holds pc 0 and 4.
      branch_flag_i = 1'b1; bta = 32'h0; id_ready = 1'b0;
      step;
      branch_flag_i = 1'b0;
      step;
      step;
      chk("pre_branch_head", id_pc, 32'h0);
      chk("pre_branch_addr", rom_addr, 32'h8);
      id_ready = 1'b1; branch_flag_i = 1'b1; bta = 32'h0000_0103;
      step;
      chk("branch_killed", {31'b0, id_valid}, 32'd0);
      chk("branch_addr", rom_addr, 32'h100);
      branch_flag_i = 1'b0;
      step;
      chk("branch_target_pc", id_pc, 32'h100);
      chk("branch_target_inst", id_inst, 32'h1000_0040);

      // Flush beats branch and is honoured under stall.
      flush = 1'b1; new_pc = 32'h20; branch_flag_i = 1'b1; bta = 32'h80; stall = 1'b1;
      step;
      chk("flush_addr", rom_addr, 32'h20);
      chk("flush_empty", {31'b0, id_valid}, 32'd0);
      flush = 1'b0; branch_flag_i = 1'b0;
      step;
      chk("stall_hold_addr", rom_addr, 32'h20);

      // PC wrap at the top of the address space.
      stall = 1'b0; branch_flag_i = 1'b1; bta = 32'hFFFF_FFFC; id_ready = 1'b0;
      step;
      chk("wrap_start", rom_addr, 32'hFFFF_FFFC);
      branch_flag_i = 1'b0;
      step;
      chk("wrap_next_pc", rom_addr, 32'h0);
      chk("wrap_entry_pc", id_pc, 32'hFFFF_FFFC);
      chk("wrap_entry_inst", id_inst, 32'h4FFF_FFFF);
      step;

      // Asynchronous reset mid-cycle with a full buffer.
      #2 rst = 1'b0;
      #1;
      chk("async_valid", {31'b0, id_valid}, 32'd0);
      chk("async_ce", {31'b0, rom_ce}, 32'd0);
      chk("async_addr", rom_addr, 32'h0);
      step;
      rst = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         step;
         rst           = ($urandom_range(0, 199) != 0);
         stall         = ($urandom_range(0, 3) == 0);
         flush         = ($urandom_range(0, 39) == 0);
         new_pc        = $urandom;
         branch_flag_i = ($urandom_range(0, 19) == 0);
         bta           = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                     : $urandom;
         id_ready      = ($urandom_range(0, 9) < 7);
      end

      rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_flag_i = 1'b0; id_ready = 1'b1;
      repeat (3) step;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
